dma_timing_ctrl: RTL and testbench

- Timing and control sequencer for the 8237A-style DMA engine.
- Arbitrates four DREQ channels using fixed or rotating priority, and runs the HRQ/HLDA bus handshake.
- Steps through the SI, S0, S1, S2, S3, S4 state sequence and drives the bus-control strobes (aen, adstb, ior, iow, memr, memw, eop) carried on the DMA control interface.
- The address/count datapath consumes xferDone/activeChan and returns tcIn/upperChange.

---
 rtl/dma_timing_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_dma_timing_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_ctrl.sv
// dma_timing_ctrl: timing and control sequencer for an 8237A-style DMA engine.
// Arbitrates the DREQ channels, runs the HRQ/HLDA handshake, walks the
// SI/S0/S1/S2/S3/S4 cycle and drives registered bus-control strobes that are
// decoded from the next state, so they only change on state-entry edges.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  SI    | idle, arbitrating requests
//  S0    | hold requested, waiting for hlda
//  S1    | upper address strobe cycle (aen, adstb)
//  S2    | dack asserted, read strobe asserted
//  S3    | write strobe added
//  S4    | last cycle of a transfer: xferDone, eop on terminal count
module dma_timing_ctrl #(
   parameter int NCH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [NCH-1:0]   dreq_i,
   input  logic [NCH-1:0]   chan_mask_i,
   input  logic             cmd_enable_i,
   input  logic             rot_priority_i,
   input  logic [2*NCH-1:0] xfer_type_i,
   input  logic [NCH-1:0]   block_mode_i,
   input  logic             hlda_i,
   input  logic             tc_in_i,
   input  logic             upper_change_i,
   input  logic             eop_in_i,
   input  logic             status_read_i,
   output logic             hrq_o,
   output logic [NCH-1:0]   dack_o,
   output logic [1:0]       active_chan_o,
   output logic             aen_o,
   output logic             adstb_o,
   output logic             ior_o,
   output logic             iow_o,
   output logic             memr_o,
   output logic             memw_o,
   output logic             eop_o,
   output logic             xfer_done_o,
   output logic [NCH-1:0]   tc_status_o
);

   localparam logic [2:0] ST_SI = 3'd0;
   localparam logic [2:0] ST_S0 = 3'd1;
   localparam logic [2:0] ST_S1 = 3'd2;
   localparam logic [2:0] ST_S2 = 3'd3;
   localparam logic [2:0] ST_S3 = 3'd4;
   localparam logic [2:0] ST_S4 = 3'd5;

   localparam logic [1:0] TYPE_WRITE = 2'b01;
   localparam logic [1:0] TYPE_READ  = 2'b10;

   logic [2:0]     state_q, state_d;
   logic [1:0]     active_q, active_d;
   // Last serviced channel; reset to 3 so the rotating search starts at ch0.
   logic [1:0]     rot_q, rot_d;
   logic           first_q, first_d;
   logic           eop_lat_q, eop_lat_d;
   logic [NCH-1:0] tc_status_q, tc_status_d;
   logic [NCH-1:0] tc_set;

   logic           hrq_q, aen_q, adstb_q, ior_q, iow_q, memr_q, memw_q;
   logic           eop_q, xfer_done_q;
   logic [NCH-1:0] dack_q;

   logic [NCH-1:0] req;
   logic [1:0]     win_fix, win_rot, winner;
   logic           xfer_end;
   logic           in_data;
   logic [1:0]     next_type;
   logic           next_read, next_write;
   logic           next_data_phase, next_wr_phase;

   assign req = dreq_i & ~chan_mask_i;

   // Priority encoders: fixed (lowest index wins) and rotating (one above last serviced).
   always_comb begin
      logic [1:0] idx;
      win_fix = 2'd0;
      win_rot = 2'd0;
      idx     = 2'd0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req[i]) win_fix = 2'(i);
      end
      for (int k = NCH; k >= 1; k--) begin
         idx = rot_q + 2'(k);
         if (req[idx]) win_rot = idx;
      end
      winner = rot_priority_i ? win_rot : win_fix;
   end

   assign in_data  = (state_q == ST_S2) || (state_q == ST_S3) || (state_q == ST_S4);
   assign xfer_end = tc_in_i || eop_lat_q || eop_in_i || !hlda_i || !block_mode_i[active_q];

   // Next-state, channel latch, firstXfer, EOP latch and terminal-count set.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      rot_d     = rot_q;
      first_d   = first_q;
      eop_lat_d = eop_lat_q;
      tc_set    = '0;
      if (in_data && eop_in_i) eop_lat_d = 1'b1;
      case (state_q)
         ST_SI: begin
            if (cmd_enable_i && (req != '0)) begin
               state_d  = ST_S0;
               active_d = winner;
            end
         end
         ST_S0: begin
            if (hlda_i) state_d = (first_q || upper_change_i) ? ST_S1 : ST_S2;
         end
         ST_S1: begin
            state_d = ST_S2;
            first_d = 1'b0;
         end
         ST_S2: state_d = ST_S3;
         ST_S3: state_d = ST_S4;
         ST_S4: begin
            if (tc_in_i) tc_set[active_q] = 1'b1;
            if (xfer_end) begin
               state_d   = ST_SI;
               first_d   = 1'b1;
               rot_d     = active_q;
               eop_lat_d = 1'b0;
            end else begin
               state_d = upper_change_i ? ST_S1 : ST_S2;
            end
         end
         default: state_d = ST_SI;
      endcase
   end

   // Set wins over a simultaneous status-read clear of the same bit.
   assign tc_status_d = (tc_status_q & ~{NCH{status_read_i}}) | tc_set;

   assign next_type       = xfer_type_i[{active_d, 1'b0} +: 2];
   assign next_read       = (next_type == TYPE_READ);
   assign next_write      = (next_type == TYPE_WRITE);
   assign next_data_phase = (state_d == ST_S2) || (state_d == ST_S3) || (state_d == ST_S4);
   assign next_wr_phase   = (state_d == ST_S3) || (state_d == ST_S4);

   // Sequencer state registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_SI;
         active_q    <= 2'd0;
         rot_q       <= 2'd3;
         first_q     <= 1'b1;
         eop_lat_q   <= 1'b0;
         tc_status_q <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         rot_q       <= rot_d;
         first_q     <= first_d;
         eop_lat_q   <= eop_lat_d;
         tc_status_q <= tc_status_d;
      end
   end

   // Bus-control strobes registered from the next state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hrq_q       <= 1'b0;
         aen_q       <= 1'b0;
         adstb_q     <= 1'b0;
         dack_q      <= '0;
         ior_q       <= 1'b0;
         iow_q       <= 1'b0;
         memr_q      <= 1'b0;
         memw_q      <= 1'b0;
         eop_q       <= 1'b0;
         xfer_done_q <= 1'b0;
      end else begin
         hrq_q       <= (state_d != ST_SI);
         aen_q       <= (state_d == ST_S1) || next_data_phase;
         adstb_q     <= (state_d == ST_S1);
         dack_q      <= next_data_phase ? (NCH'(1) << active_d) : '0;
         ior_q       <= next_data_phase && next_write;
         memr_q      <= next_data_phase && next_read;
         iow_q       <= next_wr_phase && next_read;
         memw_q      <= next_wr_phase && next_write;
         eop_q       <= (state_d == ST_S4) && tc_in_i;
         xfer_done_q <= (state_d == ST_S4);
      end
   end

   assign hrq_o         = hrq_q;
   assign dack_o        = dack_q;
   assign active_chan_o = active_q;
   assign aen_o         = aen_q;
   assign adstb_o       = adstb_q;
   assign ior_o         = ior_q;
   assign iow_o         = iow_q;
   assign memr_o        = memr_q;
   assign memw_o        = memw_q;
   assign eop_o         = eop_q;
   assign xfer_done_o   = xfer_done_q;
   assign tc_status_o   = tc_status_q;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed bench for dma_timing_ctrl with hand-computed strobe sequences.
module tb_dma_timing_ctrl;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [3:0] dreq_i, chan_mask_i, block_mode_i;
   logic       cmd_enable_i, rot_priority_i, hlda_i, tc_in_i;
   logic       upper_change_i, eop_in_i, status_read_i;
   logic [7:0] xfer_type_i;
   logic       hrq_o, aen_o, adstb_o, ior_o, iow_o, memr_o, memw_o, eop_o, xfer_done_o;
   logic [3:0] dack_o, tc_status_o;
   logic [1:0] active_chan_o;

   int checks = 0;
   int errors = 0;

   // {hrq, dack[3:0], aen, adstb, ior, iow, memr, memw, eop, xferDone}
   wire [12:0] obs = {hrq_o, dack_o, aen_o, adstb_o, ior_o, iow_o, memr_o, memw_o,
                      eop_o, xfer_done_o};

   always #5 clk_i = ~clk_i;

   dma_timing_ctrl #(.NCH(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .dreq_i(dreq_i), .chan_mask_i(chan_mask_i),
      .cmd_enable_i(cmd_enable_i), .rot_priority_i(rot_priority_i),
      .xfer_type_i(xfer_type_i), .block_mode_i(block_mode_i), .hlda_i(hlda_i),
      .tc_in_i(tc_in_i), .upper_change_i(upper_change_i), .eop_in_i(eop_in_i),
      .status_read_i(status_read_i), .hrq_o(hrq_o), .dack_o(dack_o),
      .active_chan_o(active_chan_o), .aen_o(aen_o), .adstb_o(adstb_o), .ior_o(ior_o),
      .iow_o(iow_o), .memr_o(memr_o), .memw_o(memw_o), .eop_o(eop_o),
      .xfer_done_o(xfer_done_o), .tc_status_o(tc_status_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; dreq_i = 4'b1111; chan_mask_i = 4'b0; cmd_enable_i = 1'b1;
      rot_priority_i = 1'b0; xfer_type_i = 8'h00; block_mode_i = 4'b0; hlda_i = 1'b1;
      tc_in_i = 1'b0; upper_change_i = 1'b0; eop_in_i = 1'b0; status_read_i = 1'b0;
      tick(); tick();
      checks++;
      if (obs !== 13'b0) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, 13'b0); end
      checks++;
      if (tc_status_o !== 4'b0) begin errors++; $display("FAIL reset_tcstatus got %b want 0000", tc_status_o); end
      checks++;
      if (active_chan_o !== 2'd0) begin errors++; $display("FAIL reset_active got %0d want 0", active_chan_o); end
      dreq_i = 4'b0; hlda_i = 1'b0;
      reset_i = 1'b0;
      tick();
   endtask

   task automatic test_fixed_priority();
      logic [12:0] exp [6];
      exp = '{13'b1_0000_0_0_0000_0_0, 13'b1_0000_1_1_0000_0_0, 13'b1_0010_1_0_0010_0_0,
              13'b1_0010_1_0_0110_0_0, 13'b1_0010_1_0_0110_0_1, 13'b0_0000_0_0_0000_0_0};
      do_reset();
      dreq_i = 4'b0110; rot_priority_i = 1'b0; xfer_type_i = 8'b00_00_10_00;
      block_mode_i = 4'b0; hlda_i = 1'b0; cmd_enable_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin errors++; $display("FAIL fixed_bus cycle %0d got %b want %b", i, obs, exp[i]); end
         if (i == 0) begin
            checks++;
            if (active_chan_o !== 2'd1) begin errors++; $display("FAIL fixed_active got %0d want 1", active_chan_o); end
            hlda_i = 1'b1;
         end
         if (i == 5) hlda_i = 1'b0;
      end
      tick();
      checks++;
      if (obs !== 13'b1_0000_0_0_0000_0_0 || active_chan_o !== 2'd1) begin
         errors++; $display("FAIL fixed_again got %b ch %0d want %b ch 1", obs, active_chan_o, 13'b1_0000_0_0_0000_0_0);
      end
      dreq_i = 4'b0; hlda_i = 1'b1;
      repeat (5) tick();
      checks++;
      if (obs !== 13'b0) begin errors++; $display("FAIL fixed_idle got %b want %b", obs, 13'b0); end
   endtask

   task automatic test_rotating();
      logic [1:0] ord [5];
      ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      dreq_i = 4'b1111; rot_priority_i = 1'b1; block_mode_i = 4'b0;
      xfer_type_i = 8'h00; hlda_i = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (active_chan_o !== ord[n] || hrq_o !== 1'b1) begin
            errors++; $display("FAIL rot_order service %0d got ch %0d hrq %b want ch %0d hrq 1", n, active_chan_o, hrq_o, ord[n]);
         end
         repeat (5) tick();
      end
      dreq_i = 4'b0; rot_priority_i = 1'b0;
      tick();
   endtask

   task automatic test_block_write();
      logic [12:0] exp [12];
      exp = '{13'b1_0000_0_0_0000_0_0, 13'b1_0000_1_1_0000_0_0,
              13'b1_0100_1_0_1000_0_0, 13'b1_0100_1_0_1001_0_0, 13'b1_0100_1_0_1001_0_1,
              13'b1_0100_1_0_1000_0_0, 13'b1_0100_1_0_1001_0_0, 13'b1_0100_1_0_1001_0_1,
              13'b1_0100_1_0_1000_0_0, 13'b1_0100_1_0_1001_0_0, 13'b1_0100_1_0_1001_1_1,
              13'b0_0000_0_0_0000_0_0};
      do_reset();
      dreq_i = 4'b0100; xfer_type_i = 8'b00_01_00_00; block_mode_i = 4'b0100;
      hlda_i = 1'b1; upper_change_i = 1'b0; tc_in_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin errors++; $display("FAIL block_bus cycle %0d got %b want %b", i, obs, exp[i]); end
         if (i == 9) tc_in_i = 1'b1;
         if (i == 10) begin
            checks++;
            if (tc_status_o !== 4'b0000) begin errors++; $display("FAIL block_tc_early got %b want 0000", tc_status_o); end
         end
         if (i == 11) begin
            tc_in_i = 1'b0; dreq_i = 4'b0;
            checks++;
            if (tc_status_o !== 4'b0100) begin errors++; $display("FAIL block_tcstatus got %b want 0100", tc_status_o); end
         end
      end
   endtask

   // Runs straight after the block write so tcStatus still holds 0100.
   task automatic test_eop_abort();
      logic [12:0] exp [6];
      exp = '{13'b1_0000_0_0_0000_0_0, 13'b1_0000_1_1_0000_0_0, 13'b1_0100_1_0_1000_0_0,
              13'b1_0100_1_0_1001_0_0, 13'b1_0100_1_0_1001_0_1, 13'b0_0000_0_0_0000_0_0};
      dreq_i = 4'b0100; xfer_type_i = 8'b00_01_00_00; block_mode_i = 4'b0100;
      hlda_i = 1'b1; tc_in_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin errors++; $display("FAIL eop_bus cycle %0d got %b want %b", i, obs, exp[i]); end
         if (i == 3) eop_in_i = 1'b1;
         if (i == 4) eop_in_i = 1'b0;
      end
      dreq_i = 4'b0;
      checks++;
      if (tc_status_o !== 4'b0100) begin errors++; $display("FAIL eop_tcstatus got %b want 0100", tc_status_o); end
      tick();
   endtask

   task automatic test_verify_reset();
      do_reset();
      dreq_i = 4'b1000; xfer_type_i = 8'b00_10_10_10; block_mode_i = 4'b0; hlda_i = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (obs !== 13'b1_1000_1_0_0000_0_0) begin errors++; $display("FAIL verify_s2 got %b want %b", obs, 13'b1_1000_1_0_0000_0_0); end
      tick();
      checks++;
      if (obs !== 13'b1_1000_1_0_0000_0_0) begin errors++; $display("FAIL verify_s3 got %b want %b", obs, 13'b1_1000_1_0_0000_0_0); end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0; dreq_i = 4'b0;
      checks++;
      if (obs !== 13'b0 || active_chan_o !== 2'd0) begin
         errors++; $display("FAIL verify_reset got %b ch %0d want %b ch 0", obs, active_chan_o, 13'b0);
      end
      tick();
   endtask

   task automatic test_status_read();
      do_reset();
      dreq_i = 4'b1000; xfer_type_i = 8'h00; block_mode_i = 4'b0; hlda_i = 1'b1; tc_in_i = 1'b1;
      tick();
      dreq_i = 4'b0;
      repeat (4) tick();
      checks++;
      if (eop_o !== 1'b1 || xfer_done_o !== 1'b1) begin errors++; $display("FAIL status_ch3_eop got eop %b xd %b want 1 1", eop_o, xfer_done_o); end
      tick();
      checks++;
      if (tc_status_o !== 4'b1000) begin errors++; $display("FAIL status_pre got %b want 1000", tc_status_o); end
      dreq_i = 4'b0001;
      tick();
      dreq_i = 4'b0;
      repeat (4) tick();
      checks++;
      if (eop_o !== 1'b1 || dack_o !== 4'b0001) begin errors++; $display("FAIL status_ch0_s4 got eop %b dack %b want 1 0001", eop_o, dack_o); end
      status_read_i = 1'b1;
      tick();
      status_read_i = 1'b0; tc_in_i = 1'b0;
      checks++;
      if (tc_status_o !== 4'b0001) begin errors++; $display("FAIL status_clear got %b want 0001", tc_status_o); end
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_rotating();
      test_block_write();
      test_eop_abort();
      test_verify_reset();
      test_status_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
